// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel/line counters, syncs, blank flag, frame/vblank strobes, frame counter.
// Optional macro VGA_SYNC_DELAY_EN adds one register stage to hs/vs.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // 11-bit compare constants so a sync window ending exactly at 1024 still fits
    localparam logic [10:0] H_VIS_L = 11'(H_VISIBLE);
    localparam logic [10:0] H_SS_L  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SE_L  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_L = 11'(V_VISIBLE);
    localparam logic [10:0] V_SS_L  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SE_L  = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

    generate
        if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_param_err
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    logic [9:0]  hc_q, hc_d, vc_q, vc_d;
    logic        hs_q, hs_d, vs_q, vs_d;
    logic        blank_q, blank_d;
    logic        fs_q, fs_d, vbs_q, vbs_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [10:0] hx_s, vy_s;

    assign hx_s = {1'b0, hc_d};
    assign vy_s = {1'b0, vc_d};

    // Next raster position: hc wraps every line, vc advances on that wrap
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            if (vc_q == V_LAST) begin
                vc_d = 10'd0;
            end else begin
                vc_d = vc_q + 10'd1;
            end
        end else begin
            hc_d = hc_q + 10'd1;
        end
    end

    // Decode the next position so all registered outputs line up with DrawX/DrawY
    always_comb begin
        blank_d       = (hx_s < H_VIS_L) && (vy_s < V_VIS_L);
        hs_d          = !((hx_s >= H_SS_L) && (hx_s < H_SE_L));
        vs_d          = !((vy_s >= V_SS_L) && (vy_s < V_SE_L));
        fs_d          = (hc_d == 10'd0) && (vc_d == 10'd0);
        vbs_d         = (hc_d == 10'd0) && (vy_s == V_VIS_L);
        frame_count_d = frame_count_q;
        if (vbs_d) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // Reset parks the raster on its last position so the first edge starts frame (0,0)
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q          <= H_LAST;
            vc_q          <= V_LAST;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            fs_q          <= 1'b0;
            vbs_q         <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            fs_q          <= fs_d;
            vbs_q         <= vbs_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_dly_q, vs_dly_q;

    // Extra sync stage for pixel pipelines that register colour one cycle late
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_dly_q <= 1'b1;
            vs_dly_q <= 1'b1;
        end else begin
            hs_dly_q <= hs_q;
            vs_dly_q <= vs_q;
        end
    end

    assign hs = hs_dly_q;
    assign vs = vs_dly_q;
`else
    assign hs = hs_q;
    assign vs = vs_q;
`endif

    assign blank        = blank_q;
    assign DrawX        = hc_q;
    assign DrawY        = vc_q;
    assign frame_start  = fs_q;
    assign vblank_start = vbs_q;
    assign frame_count  = frame_count_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. Outputs: current pixel coordinates, active-video flag, horizontal/vertical sync, and per-frame event pulses. Sits directly upstream of every sprite/pixel stage (the boss sprite renderer included), which consume `DrawX`, `DrawY` and `blank` each cycle. Also gives game logic a vertical-blank strobe and a frame counter, so positions are updated only outside active video.

## Interface
Parameters:
- `H_VISIBLE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_VISIBLE`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BACK`, 33: vertical back porch, in lines

Ports:
- `vga_clk` in 1: pixel clock; all state on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `hs` out 1: horizontal sync, active low
- `vs` out 1: vertical sync, active low
- `blank` out 1: 1 = visible pixel (draw), 0 = blanking
- `DrawX` out 10: current column, 0..H_TOTAL-1
- `DrawY` out 10: current line, 0..V_TOTAL-1
- `frame_start` out 1: one-cycle pulse at (0,0)
- `vblank_start` out 1: one-cycle pulse at (0,V_VISIBLE)
- `frame_count` out 16: count of vblank_start events since reset

## Operation
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be ≤ 1024; a larger value is a parameter error.
- Counters hc/vc are registered and drive DrawX/DrawY directly.
  - hc increments every cycle and wraps H_TOTAL-1 → 0.
  - On that wrap, vc increments and wraps V_TOTAL-1 → 0.
- All other outputs are registers computed from the next counter value, so every output describes the same (DrawX, DrawY) in the same cycle:
  - blank = (x < H_VISIBLE) && (y < V_VISIBLE)
  - hs = 0 iff H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC (656..751)
  - vs = 0 iff V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC (490..491)
  - frame_start = (x==0 && y==0)
  - vblank_start = (x==0 && y==V_VISIBLE)
- frame_count increments by 1 in the cycle vblank_start is 1. It wraps 0xFFFF → 0 without saturating.
- Reset state is the last raster position, so the first active edge begins a clean frame:
  - DrawX=H_TOTAL-1, DrawY=V_TOTAL-1
  - hs=1, vs=1, blank=0, frame_start=0, vblank_start=0, frame_count=0
- Reset asserted mid-frame forces the reset state immediately (asynchronous). Release restarts at (0,0) on the next edge; no partial line or frame is resumed.

## Timing
- First rising edge after reset_n release: DrawX=0, DrawY=0, blank=1, frame_start=1.
- Line period is H_TOTAL cycles (800); frame period is H_TOTAL·V_TOTAL cycles (420000).
- hs is low for exactly H_SYNC consecutive cycles per line, on every line including vertical blanking.
- vs goes low and high at DrawX=0 of the affected lines, i.e. low for V_SYNC·H_TOTAL cycles (1600).
- frame_start and vblank_start are each high for exactly one cycle per frame; they are never high together.
- No input handshake. Consumers sample the outputs every cycle.

## Configuration
- `VGA_SYNC_DELAY_EN` defined:
  - hs and vs pass through one extra register stage, so they lag DrawX/DrawY/blank by one cycle.
  - This matches pixel stages that register color one cycle after sampling coordinates.
  - Delay registers reset to 1.
  - First hs falling edge appears while DrawX=657.
- `VGA_SYNC_DELAY_EN` undefined: hs/vs are aligned with DrawX/DrawY as specified above.
- All other outputs are unaffected by the macro.

## Test plan
- Reset held 10 cycles → outputs DrawX=799, DrawY=524, hs=1, vs=1, blank=0, frame_count=0; first edge after release → (0,0), blank=1, frame_start=1.
- Free-run one line → blank=1 for DrawX 0..639 and 0 for 640..799; hs=0 exactly for DrawX 656..751 (96 cycles); DrawX 799→0 with DrawY +1.
- Free-run one frame → vs=0 exactly for DrawY 490..491 (1600 cycles); vblank_start once at (0,480); frame_count 0→1; next frame_start 420000 cycles after the first.
- Assert reset_n at (300,200) for 3 cycles → outputs take reset values asynchronously; after release, (0,0) with frame_start=1; frame_count=0 until the next vblank_start.
- Preload/force frame_count=0xFFFF, run to vblank_start → frame_count=0x0000.
- Build with VGA_SYNC_DELAY_EN → hs falls while DrawX=657 and vs falls at (1,490); blank/DrawX timing identical to the default build.
